// File: rtl/montgomery_encode_if.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_encode_if
// Description : Handshake bundle for montgomery_encode. The load side carries
//               the modulus q and operand a_in with in_valid/in_ready; the
//               result side carries T with out_valid/out_ready.
//               master : host/load path plus result consumer
//               slave  : the encoder
// Revision    : 1.0 - initial release
// ============================================================================
interface montgomery_encode_if #(
    parameter int LOGQ = 64
);
    logic [LOGQ-1:0] q;
    logic [LOGQ-1:0] a_in;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] T;
    logic            out_valid;
    logic            out_ready;

    modport master (
        output q, a_in, in_valid, out_ready,
        input  in_ready, T, out_valid
    );

    modport slave (
        input  q, a_in, in_valid, out_ready,
        output in_ready, T, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/montgomery_encode.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_encode
// Description : Converts an operand into the Montgomery domain,
//               T = a * 2^LOGR mod q, by LOGR modular doublings performed
//               STEP at a time per clock.
// Ports       : clk            clock, rising edge
//               rst            synchronous active-high reset
//               bus.q          modulus (odd, MSB set), sampled on accept
//               bus.a_in       operand, a_in < 2q, sampled on accept
//               bus.in_valid   load request
//               bus.in_ready   high in IDLE while not in reset
//               bus.T          result in [0,q)
//               bus.out_valid  result valid, held until out_ready
//               bus.out_ready  consumer accepts result
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_encode #(
    parameter int LOGQ = 64,
    parameter int LOGR = 64,
    parameter int STEP = 1,
    parameter int CNTW = 7
) (
    input  wire logic          clk,
    input  wire logic          rst,
    montgomery_encode_if.slave bus
);

    localparam int c_N_STEPS = LOGR / STEP;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [LOGQ-1:0] r_q;
    logic [LOGQ-1:0] r_x;
    logic [LOGQ-1:0] r_t;
    logic            r_out_valid;
    logic [CNTW-1:0] r_cnt;

    // Load-time reduction of a_in from [0,2q) to [0,q). The difference is
    // taken at LOGQ+1 bits; its MSB is a borrow flag: set exactly when
    // a_in < q, because a non-negative difference is below q < 2^LOGQ while
    // a wrapped one is at least 2^(LOGQ+1) - 2^LOGQ.
    logic [LOGQ:0]   w_ld_diff;
    logic [LOGQ-1:0] w_ld_x;

    assign w_ld_diff = {1'b0, bus.a_in} - {1'b0, bus.q};
    assign w_ld_x    = w_ld_diff[LOGQ] ? bus.a_in : w_ld_diff[LOGQ-1:0];

    // STEP chained modular doublings. The same borrow argument applies:
    // y = 2x < 2q, so y - q either fits in LOGQ bits or borrows into the MSB.
    // When it borrows, y < q and thus y itself fits in LOGQ bits.
    logic [LOGQ-1:0] w_chain [STEP+1];

    assign w_chain[0] = r_x;

    generate
        for (genvar i = 0; i < STEP; i++) begin : g_dbl
            logic [LOGQ:0] w_diff;
            assign w_diff       = {w_chain[i], 1'b0} - {1'b0, r_q};
            assign w_chain[i+1] = w_diff[LOGQ] ? {w_chain[i][LOGQ-2:0], 1'b0}
                                               : w_diff[LOGQ-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_q         <= '0;
            r_x         <= '0;
            r_t         <= '0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (bus.in_valid) begin
                        r_q     <= bus.q;
                        r_x     <= w_ld_x;
                        r_cnt   <= '0;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    r_x   <= w_chain[STEP];
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == CNTW'(c_N_STEPS - 1)) begin
                        r_t         <= w_chain[STEP];
                        r_out_valid <= 1'b1;
                        r_state     <= c_S_DONE;
                    end
                end
                c_S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst directly so a request is never accepted while
    // reset is asserted, even though the state is already IDLE.
    assign bus.in_ready  = (r_state == c_S_IDLE) && !rst;
    assign bus.T         = r_t;
    assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_montgomery_encode.sv
`default_nettype none
// ============================================================================
// Module      : tb_montgomery_encode
// Description : Self-checking bench for montgomery_encode. Expected results
//               come from fixed constants and a wide-arithmetic reference
//               (a * 2^LOGR) mod q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_encode;

    localparam int LOGQ = 64;
    localparam int LOGR = 64;
    localparam int STEP = 1;
    localparam int CNTW = 7;
    localparam int c_N  = LOGR / STEP;
    localparam logic [63:0] c_Q0 = 64'hb040000000000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    montgomery_encode_if #(.LOGQ(LOGQ)) bus ();

    montgomery_encode #(
        .LOGQ (LOGQ),
        .LOGR (LOGR),
        .STEP (STEP),
        .CNTW (CNTW)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [63:0] ref_encode(input logic [63:0] a, input logic [63:0] qv);
        logic [127:0] p;
        logic [127:0] m;
        p = {a, 64'd0};
        m = p % {64'd0, qv};
        return m[63:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge. Loads one operand, scrambles the inputs after
    // acceptance, and returns T plus the number of edges from acceptance to
    // out_valid (sampled at negedges).
    task automatic run_op(input logic [63:0] a, input logic [63:0] qv,
                          output logic [63:0] t, output int lat);
        int n;
        bus.a_in     = a;
        bus.q        = qv;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
            bus.in_valid = 1'b0;
            t   = '0;
            lat = -1;
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_in     = rand64();
        bus.q        = rand64();
        lat = 0;
        while (!bus.out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        t = bus.T;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("drain_in_ready",  {63'd0, bus.in_ready},  64'd1);
        bus.out_ready = 1'b0;
    endtask

    logic [63:0] dir_a   [5];
    logic [63:0] dir_exp [5];

    initial begin
        logic [63:0] t;
        logic [63:0] t0;
        logic [63:0] qv;
        logic [63:0] a;
        int          lat;
        int          hits [$];
        bit          saw;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_in      = '0;
        bus.q         = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_T",         bus.T,                  64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);

        // Directed vectors with known answers
        dir_a[0] = 64'd1;       dir_exp[0] = 64'h4fbfffffffffffff;
        dir_a[1] = 64'd2;       dir_exp[1] = 64'h9f7ffffffffffffe;
        dir_a[2] = c_Q0 - 64'd1; dir_exp[2] = 64'h6080000000000002;
        dir_a[3] = 64'd0;       dir_exp[3] = 64'd0;
        dir_a[4] = c_Q0;        dir_exp[4] = 64'd0;
        for (int i = 0; i < 5; i++) begin
            run_op(dir_a[i], c_Q0, t, lat);
            check($sformatf("dir_T[%0d]", i), t, dir_exp[i]);
            check($sformatf("dir_lat[%0d]", i), 64'(lat), 64'(c_N));
            check("done_in_ready", {63'd0, bus.in_ready}, 64'd0);
            drain();
        end

        // Hold in DONE for 10 cycles with out_ready low
        run_op(64'd1, c_Q0, t0, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_T",         bus.T,                  64'h4fbfffffffffffff);
            check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("hold_in_ready",  {63'd0, bus.in_ready},  64'd0);
        end
        drain();

        // Back-to-back: in_valid and out_ready held high (out_ready high in RUN too)
        a = rand64() % c_Q0;
        bus.a_in      = a;
        bus.q         = c_Q0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 4 * (c_N + 2) + 10 && hits.size() < 3; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                hits.push_back(cyc);
                check("b2b_T", bus.T, ref_encode(a, c_Q0));
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_count", 64'(hits.size()), 64'd3);
        for (int i = 1; i < hits.size(); i++)
            check("b2b_period", 64'(hits[i] - hits[i-1]), 64'(c_N + 2));
        repeat (c_N + 4) @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b_idle", {63'd0, bus.in_ready}, 64'd1);

        // Reset mid-RUN abandons the operation
        bus.a_in     = 64'd7;
        bus.q        = c_Q0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        saw = 1'b0;
        repeat (c_N + 5) begin
            @(negedge clk);
            if (bus.out_valid) saw = 1'b1;
        end
        check("midrst_no_output", {63'd0, saw}, 64'd0);
        run_op(64'd1, c_Q0, t, lat);
        check("midrst_T",   t,          64'h4fbfffffffffffff);
        check("midrst_lat", 64'(lat),   64'(c_N));
        drain();

        // Randomized moduli and operands, including a in [q,2q)
        for (int i = 0; i < 40; i++) begin
            qv = rand64();
            qv[63] = 1'b1;
            qv[0]  = 1'b1;
            if ($urandom_range(3) == 0)
                a = qv + (rand64() % (64'd0 - qv));
            else
                a = rand64() % qv;
            run_op(a, qv, t, lat);
            check($sformatf("rnd_T[%0d]", i), t, ref_encode(a, qv));
            check($sformatf("rnd_lat[%0d]", i), 64'(lat), 64'(c_N));
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
